// File: rtl/dunc16_sequencer_if.sv
// Memory-port handshake between the DUNC16 sequencer (master) and memory (slave).
interface dunc16_sequencer_if;
  logic MEM_REQ;
  logic MEM_WE;
  logic ADDR_SEL;
  logic MEM_RDY;

  modport master (output MEM_REQ, output MEM_WE, output ADDR_SEL, input MEM_RDY);
  modport slave  (input MEM_REQ, input MEM_WE, input ADDR_SEL, output MEM_RDY);
endinterface

// File: rtl/dunc16_sequencer.sv
// DUNC16 control sequencer: fetch/decode/mem/write-back stepping with a
// memory wait-state watchdog that parks the machine in FAULT.
module dunc16_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      CLK,
  input  logic                      RESET,
  dunc16_sequencer_if.master        mem,
  input  logic [15:0]               IR,
  input  logic                      AC_ZERO,
  input  logic                      CONT,
  output logic                      IR_LOAD,
  output logic                      PC_INC,
  output logic                      PC_LOAD,
  output logic                      MD_LOAD,
  output logic                      AC_LOAD,
  output logic [1:0]                ALU_OP,
  output logic                      HALTED,
  output logic                      BUS_ERR,
  output logic [2:0]                STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic [3:0] opc;
  logic       busy, timed_out;
  logic       mem_req, mem_we, addr_sel;

  assign opc  = IR[15:12];
  assign busy = (state == S_FETCH) || (state == S_MEM);
  // The edge that would complete the TIMEOUT-th waiting cycle goes to FAULT
  // instead; a ready in that same cycle still wins.
  assign timed_out = busy && !mem.MEM_RDY && (wait_cnt == 8'(TIMEOUT - 1));

  assign mem.MEM_REQ  = mem_req;
  assign mem.MEM_WE   = mem_we;
  assign mem.ADDR_SEL = addr_sel;
  assign STATE        = state;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || mem.MEM_RDY)
        wait_cnt <= '0;
      else if (busy)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    IR_LOAD   = 1'b0;
    PC_INC    = 1'b0;
    PC_LOAD   = 1'b0;
    MD_LOAD   = 1'b0;
    AC_LOAD   = 1'b0;
    ALU_OP    = 2'b00;
    HALTED    = 1'b0;
    BUS_ERR   = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem.MEM_RDY) begin
          IR_LOAD   = 1'b1;
          PC_INC    = 1'b1;
          state_nxt = S_DECODE;
        end else if (timed_out) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        case (opc)
          4'd0:                         state_nxt = S_HALT;
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5: state_nxt = S_MEM;
          4'd6: begin PC_LOAD = 1'b1;    state_nxt = S_FETCH; end
          4'd7: begin PC_LOAD = AC_ZERO; state_nxt = S_FETCH; end
          default:                      state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opc == 4'd2);
        if (mem.MEM_RDY) begin
          if (opc == 4'd2) begin
            state_nxt = S_FETCH;
          end else begin
            MD_LOAD   = 1'b1;
            state_nxt = S_WB;
          end
        end else if (timed_out) begin
          state_nxt = S_FAULT;
        end
      end
      S_WB: begin
        AC_LOAD = 1'b1;
        case (opc)
          4'd3:    ALU_OP = 2'b01;
          4'd4:    ALU_OP = 2'b10;
          4'd5:    ALU_OP = 2'b11;
          default: ALU_OP = 2'b00;
        endcase
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        HALTED = 1'b1;
        if (CONT) state_nxt = S_FETCH;
      end
      S_FAULT: BUS_ERR = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dunc16_sequencer.sv
// Instruction-level bench: each instruction's expected per-cycle output
// trace is built from its opcode, wait-state counts and AC_ZERO.
module tb_dunc16_sequencer;
  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] IR = '0;
  logic        AC_ZERO = 1'b0;
  logic        CONT = 1'b0;
  logic        IR_LOAD, PC_INC, PC_LOAD, MD_LOAD, AC_LOAD, HALTED, BUS_ERR;
  logic [1:0]  ALU_OP;
  logic [2:0]  STATE;

  dunc16_sequencer_if bus();

  dunc16_sequencer #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .mem(bus), .IR(IR), .AC_ZERO(AC_ZERO), .CONT(CONT),
    .IR_LOAD(IR_LOAD), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD), .MD_LOAD(MD_LOAD),
    .AC_LOAD(AC_LOAD), .ALU_OP(ALU_OP), .HALTED(HALTED), .BUS_ERR(BUS_ERR),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // {STATE, REQ, WE, ASEL, IRL, PCI, PCL, MDL, ACL, ALU, HALTED, BUS_ERR}
  logic [14:0] obs;
  assign obs = {STATE, bus.MEM_REQ, bus.MEM_WE, bus.ADDR_SEL, IR_LOAD, PC_INC,
                PC_LOAD, MD_LOAD, AC_LOAD, ALU_OP, HALTED, BUS_ERR};

  function automatic logic [14:0] ev(int st, bit req, bit we, bit as, bit irl, bit pci,
                                     bit pcl, bit mdl, bit acl, logic [1:0] alu, bit h, bit b);
    return {3'(st), req, we, as, irl, pci, pcl, mdl, acl, alu, h, b};
  endfunction

  function automatic logic [1:0] alu_of(logic [3:0] op);
    case (op)
      4'd3:    return 2'b01;
      4'd4:    return 2'b10;
      4'd5:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(string tag, logic [14:0] got, logic [14:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered just after a falling edge; drive, check, advance one cycle.
  task automatic cyc(string tag, bit rdy, bit cont, logic [14:0] exp);
    bus.MEM_RDY = rdy;
    CONT = cont;
    #1 chk(tag, obs, exp);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    #2 RESET = 1'b0;
    #1 chk("rst_async", obs, 15'h0);
    bus.MEM_RDY = 1'b1;
    CONT = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1 chk("rst_hold", obs, 15'h0);
    @(negedge CLK);
    RESET = 1'b1;
    cyc("idle", rnd(), rnd(), 15'h0);
  endtask

  task automatic fault_hold();
    for (int i = 0; i < 3; i++)
      cyc("fault", rnd(), rnd(), ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
    do_reset();
  endtask

  task automatic run_instr(logic [15:0] ir, bit acz, int fw, int mw, int hn, bit abort);
    logic [3:0] op;
    bit         pcl, we, last;
    op = ir[15:12];
    IR = ir;
    AC_ZERO = acz;
    for (int k = 0; k <= fw; k++) begin
      if (k == TO) begin fault_hold(); return; end
      last = (k == fw);
      cyc("fetch", last, rnd(), ev(1, 1, 0, 0, last, last, 0, 0, 0, 2'b00, 0, 0));
    end
    pcl = (op == 4'd6) || (op == 4'd7 && acz);
    cyc("decode", rnd(), rnd(), ev(2, 0, 0, 0, 0, 0, pcl, 0, 0, 2'b00, 0, 0));
    if (op == 4'd0) begin
      for (int i = 0; i < hn; i++)
        cyc("halt", rnd(), 0, ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
      cyc("halt_cont", rnd(), 1, ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
      CONT = 1'b0;
      return;
    end
    if (op > 4'd5) return;
    we = (op == 4'd2);
    for (int k = 0; k <= mw; k++) begin
      if (k == TO) begin fault_hold(); return; end
      if (abort && k == 1) begin do_reset(); return; end
      last = (k == mw);
      cyc("mem", last, rnd(), ev(3, 1, we, 1, 0, 0, 0, last && !we, 0, 2'b00, 0, 0));
    end
    if (!we)
      cyc("wb", rnd(), rnd(), ev(4, 0, 0, 0, 0, 0, 0, 0, 1, alu_of(op), 0, 0));
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 39));
    if (r == 39) return TO;
    if (r == 38) return TO - 1;
    if (r < 28) return 0;
    return int'($urandom_range(1, 4));
  endfunction

  initial begin
    bus.MEM_RDY = 1'b1;
    @(negedge CLK);
    do_reset();
    // directed: loads, store with waits, branches, halt, watchdog edges
    run_instr(16'h1005, 0, 0, 0, 0, 0);
    run_instr(16'h4005, 0, 0, 0, 0, 0);
    run_instr(16'h2010, 0, 0, 3, 0, 0);
    run_instr(16'h7ABC, 1, 0, 0, 0, 0);
    run_instr(16'h7ABC, 0, 0, 0, 0, 0);
    run_instr(16'h0000, 0, 0, 0, 10, 0);
    run_instr(16'h9000, 0, TO - 1, 0, 0, 0);
    run_instr(16'h3001, 0, 0, TO - 1, 0, 0);
    run_instr(16'h5001, 0, TO, 0, 0, 0);
    run_instr(16'h2001, 0, 0, TO, 0, 0);
    run_instr(16'h1005, 0, 0, 5, 0, 1);
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ir;
      ir = 16'($urandom);
      if ($urandom_range(0, 1) == 0) ir[15:12] = 4'($urandom_range(0, 7));
      run_instr(ir, rnd(), pick_wait(), pick_wait(), int'($urandom_range(0, 4)),
                $urandom_range(0, 49) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dunc16_sequencer.md
# dunc16_sequencer

Control sequencer for the 16-bit DUNC16 accumulator datapath (PC, IR, AC, MD, ALU, shared memory port). Steps each instruction through fetch, decode, memory and write-back. Drives every datapath load/increment strobe and the ALU operation. Owns the memory request/ready handshake, including a wait-state timeout.

## Interface

- TIMEOUT, 15: maximum cycles MEM_REQ may stay pending without MEM_RDY before a bus fault (1..255).
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IR  in  16  instruction register contents; opcode IR[15:12], operand address IR[11:0].
- AC_ZERO  in  1  datapath flag, AC == 16'h0000.
- MEM_RDY  in  1  memory completes the current access this cycle.
- CONT  in  1  resume pulse from HALT.
- MEM_REQ  out  1  memory access request.
- MEM_WE  out  1  write qualifier, valid with MEM_REQ.
- ADDR_SEL  out  1  address mux: 0 = PC, 1 = IR[11:0].
- IR_LOAD, PC_INC, PC_LOAD, MD_LOAD, AC_LOAD  out  1 each  datapath strobes.
- ALU_OP  out  2  00 pass MD, 01 AC+MD, 10 AC−MD, 11 AC&MD.
- HALTED  out  1  sequencer in HALT.
- BUS_ERR  out  1  sequencer in FAULT.
- STATE  out  3  encoded state, for debug.

## Operation

- States (STATE code): IDLE 0, FETCH 1, DECODE 2, MEM 3, WB 4, HALT 5, FAULT 6.
- IDLE: held while RESET is low. Advances to FETCH on the first CLK edge after release.
- FETCH: MEM_REQ=1, ADDR_SEL=0, MEM_WE=0.
  - Stays in FETCH while MEM_RDY=0.
  - When MEM_RDY=1: IR_LOAD=1 and PC_INC=1 in that cycle, then go to DECODE.
- DECODE, by opcode:
  - 0 HLT: go to HALT.
  - 1 LDA, 3 ADD, 4 SUB, 5 AND: go to MEM (read).
  - 2 STA: go to MEM (write).
  - 6 JMP: PC_LOAD=1, go to FETCH.
  - 7 JZ: PC_LOAD=AC_ZERO, go to FETCH.
  - 8–15: NOP, go to FETCH.
- MEM: MEM_REQ=1, ADDR_SEL=1, MEM_WE=1 only for STA.
  - Waits for MEM_RDY.
  - On MEM_RDY, read ops: MD_LOAD=1, go to WB.
  - On MEM_RDY, STA: go to FETCH.
- WB: AC_LOAD=1, go to FETCH.
  - ALU_OP: LDA 00, ADD 01, SUB 10, AND 11.
- ALU_OP is 00 in every state other than WB.
- HALT: HALTED=1, no strobes. CONT=1 moves to FETCH.
- FAULT: BUS_ERR=1, no strobes. Only RESET exits.
- Wait counter:
  - Cleared on entry to FETCH or MEM, and whenever MEM_RDY=1.
  - Increments each cycle MEM_REQ=1 and MEM_RDY=0.
  - When it reaches TIMEOUT with MEM_RDY still 0, next state is FAULT.
- MEM_RDY outside FETCH/MEM is ignored. CONT outside HALT is ignored.

## Timing

- State register and wait counter are flops. All outputs are combinational from state, IR, AC_ZERO and MEM_RDY.
- Reset: while RESET=0, all outputs are 0 and STATE=0. This holds asynchronously, mid-access included. A pending MEM_REQ drops immediately.
- Zero-wait-state instruction cycles:
  - LDA/ADD/SUB/AND: 4 (FETCH, DECODE, MEM, WB).
  - STA: 3.
  - JMP/JZ/NOP: 2.
- Each wait state adds one cycle to FETCH or MEM.
- MEM_REQ, MEM_WE and ADDR_SEL are stable from state entry until the cycle in which MEM_RDY=1.
- MEM_RDY=1 in the same cycle MEM_REQ rises is a valid zero-wait completion.
- IR is sampled in DECODE; it must be stable from the IR_LOAD edge onward. AC_ZERO is sampled in DECODE for JZ.
- MEM_RDY arriving in the same cycle the counter hits TIMEOUT counts as completion; no FAULT.
- First MEM_REQ is 1 cycle after RESET deasserts, i.e. the cycle after the IDLE→FETCH edge.

## Test plan

- Reset/boot: hold RESET=0 for 2 edges with MEM_RDY=1 → all outputs 0, STATE=0. Release → STATE=0 for 1 cycle, then STATE=1 with MEM_REQ=1, ADDR_SEL=0.
- Zero-wait LDA (IR=16'h1005), MEM_RDY tied 1:
  - STATE sequence 1,2,3,4,1.
  - IR_LOAD+PC_INC in cycle 1; MD_LOAD with ADDR_SEL=1 in cycle 3; AC_LOAD with ALU_OP=00 in cycle 4.
  - Repeat with SUB (16'h4005) → ALU_OP=10 in WB.
- STA with 3 wait states (IR=16'h2010, MEM_RDY high on 4th MEM cycle) → MEM_WE=1 and ADDR_SEL=1 held for 4 cycles. Back to FETCH, no AC_LOAD or MD_LOAD.
- Branches:
  - JZ (16'h7ABC) with AC_ZERO=1 → PC_LOAD=1 in DECODE.
  - JZ with AC_ZERO=0 → PC_LOAD=0.
  - Both return to FETCH after 2 cycles.
- Halt/resume: HLT (16'h0000) → HALTED=1 held for 10 cycles with no strobes. CONT pulse → next STATE=1, HALTED=0.
- Timeout: MEM_RDY held 0 in FETCH with TIMEOUT=15 → STATE=6 and BUS_ERR=1 after the 15th waiting cycle, MEM_REQ=0, stays until RESET. Repeat with MEM_RDY on the 15th cycle → no fault. Assert RESET mid-MEM → outputs 0 immediately.
